// File: rtl/ecc_enc_stage_if.sv
// ecc_enc_stage_if: upstream word handshake and downstream codeword handshake of the
// SEC encoder stage. The stage itself uses the slave modport; the environment around it
// (producer plus consumer) uses the master modport.
interface ecc_enc_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [7:0]  out_check;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_check
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_check
   );
endinterface

// File: rtl/ecc_enc_stage.sv
// ecc_enc_stage: computes 8 SEC check bits for each accepted 32-bit word and queues the
// 40-bit codeword in a small circular FIFO in front of the downstream decoder.
// Optional feature macro: ECC_ERR_INJECT_EN adds inj_en/inj_bit to flip one stored bit.
module ecc_enc_stage #(
   parameter int unsigned FIFO_DEPTH = 2,  // 2, 4 or 8
   parameter int unsigned CNT_W      = 16
) (
   input  logic             CK,
   input  logic             RN,
`ifdef ECC_ERR_INJECT_EN
   input  logic             inj_en,
   input  logic [5:0]       inj_bit,
`endif
   ecc_enc_stage_if.slave   bus,
   output logic [CNT_W-1:0] word_cnt
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned OccW = PtrW + 1;

   typedef enum logic [1:0] {StEmpty, StPart, StFull} occ_state_e;

   occ_state_e       state_q, state_d;
   logic [OccW-1:0]  occ_q, occ_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [39:0]      mem_q [FIFO_DEPTH];

   logic             in_ready;
   logic             out_valid;
   logic             push;
   logic             pop;
   logic [7:0]       check;
   logic [39:0]      codeword;

   // Check-bit encoder: even parity over each bit's 12-bit data set, plus optional injection
   always_comb begin
      check[0] = ^(bus.in_data & 32'h00FF_1111);
      check[1] = ^(bus.in_data & 32'hFF00_2222);
      check[2] = ^(bus.in_data & 32'h0F0F_4444);
      check[3] = ^(bus.in_data & 32'hF0F0_8888);
      check[4] = ^(bus.in_data & 32'h1111_00FF);
      check[5] = ^(bus.in_data & 32'h2222_FF00);
      check[6] = ^(bus.in_data & 32'h4444_0F0F);
      check[7] = ^(bus.in_data & 32'h8888_F0F0);
      codeword = {check, bus.in_data};
`ifdef ECC_ERR_INJECT_EN
      // Indices 40..63 fall outside the codeword and leave it untouched
      if (inj_en && (inj_bit < 6'd40)) begin
         codeword = codeword ^ (40'd1 << inj_bit);
      end
`endif
   end

   assign push = bus.in_valid & in_ready;
   assign pop  = bus.out_ready & out_valid;

   // Occupancy state register
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state_q <= StEmpty;
         occ_q   <= '0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
      end
   end

   // Occupancy next state; push+pop together leaves the count unchanged
   always_comb begin
      occ_d = occ_q;
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
      if (occ_d == '0) begin
         state_d = StEmpty;
      end else if (occ_d == OccW'(FIFO_DEPTH)) begin
         state_d = StFull;
      end else begin
         state_d = StPart;
      end
   end

   // Handshake outputs decoded from registered occupancy only
   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      unique case (state_q)
         StEmpty: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
         end
         StPart: begin
            in_ready  = 1'b1;
            out_valid = 1'b1;
         end
         StFull: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
         end
      endcase
   end

   // Pointer and counter next state; power-of-two depth makes pointer overflow the wrap
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = push ? cnt_q + 1'b1 : cnt_q;
   end

   // Pointer and word counter registers
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Codeword storage; cleared on reset so the idle head reads as zero
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= codeword;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = mem_q[rd_ptr_q][31:0];
   assign bus.out_check = mem_q[rd_ptr_q][39:32];
   assign word_cnt      = cnt_q;

endmodule

// File: tb/tb_ecc_enc_stage.sv
// tb_ecc_enc_stage: directed and random stimulus against a queue-based reference model
// of the encoder stage; a second small instance exercises the counter wrap.
module tb_ecc_enc_stage;

   localparam int DEPTH = 2;

   logic        CK = 1'b0;
   logic        RN = 1'b0;
   logic [15:0] word_cnt;
   logic [3:0]  word_cnt2;
`ifdef ECC_ERR_INJECT_EN
   logic        inj_en;
   logic [5:0]  inj_bit;
`endif

   ecc_enc_stage_if bus ();
   ecc_enc_stage_if bus2 ();

   ecc_enc_stage #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
      .CK       (CK),
      .RN       (RN),
`ifdef ECC_ERR_INJECT_EN
      .inj_en   (inj_en),
      .inj_bit  (inj_bit),
`endif
      .bus      (bus.slave),
      .word_cnt (word_cnt)
   );

   ecc_enc_stage #(.FIFO_DEPTH(4), .CNT_W(4)) dut2 (
      .CK       (CK),
      .RN       (RN),
`ifdef ECC_ERR_INJECT_EN
      .inj_en   (1'b0),
      .inj_bit  (6'd0),
`endif
      .bus      (bus2.slave),
      .word_cnt (word_cnt2)
   );

   always #5 CK = ~CK;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference parity helpers: contiguous ranges and stride-4 groups of data bits
   function automatic logic par_rng(input logic [31:0] d, input int lo, input int hi);
      logic p = 1'b0;
      for (int i = lo; i <= hi; i++) p ^= d[i];
      return p;
   endfunction

   function automatic logic par_str(input logic [31:0] d, input int base);
      logic p = 1'b0;
      for (int m = 0; m < 4; m++) p ^= d[base + 4 * m];
      return p;
   endfunction

   function automatic logic [7:0] model_check(input logic [31:0] d);
      logic [7:0] c;
      c[0] = par_rng(d, 16, 23) ^ par_str(d, 0);
      c[1] = par_rng(d, 24, 31) ^ par_str(d, 1);
      c[2] = par_rng(d, 16, 19) ^ par_rng(d, 24, 27) ^ par_str(d, 2);
      c[3] = par_rng(d, 20, 23) ^ par_rng(d, 28, 31) ^ par_str(d, 3);
      c[4] = par_rng(d, 0, 7) ^ par_str(d, 16);
      c[5] = par_rng(d, 8, 15) ^ par_str(d, 17);
      c[6] = par_rng(d, 0, 3) ^ par_rng(d, 8, 11) ^ par_str(d, 18);
      c[7] = par_rng(d, 4, 7) ^ par_rng(d, 12, 15) ^ par_str(d, 19);
      return c;
   endfunction

   // Reference model: a queue of codewords and a push counter
   logic [39:0] model_q[$];
   logic [15:0] m_cnt = '0;
   logic        m_push;
   logic        m_pop;
   logic [39:0] m_cw;

   always @(posedge CK or negedge RN) begin
      if (!RN) begin
         model_q.delete();
         m_cnt = '0;
      end else begin
         m_push = bus.in_valid && (model_q.size() < DEPTH);
         m_pop  = bus.out_ready && (model_q.size() > 0);
         m_cw   = {model_check(bus.in_data), bus.in_data};
`ifdef ECC_ERR_INJECT_EN
         if (inj_en && (inj_bit < 6'd40)) m_cw[inj_bit] = ~m_cw[inj_bit];
`endif
         if (m_pop) void'(model_q.pop_front());
         if (m_push) begin
            model_q.push_back(m_cw);
            m_cnt = m_cnt + 16'd1;
         end
      end
   end

   // Compare process: every falling edge, all outputs against the model
   always @(negedge CK) begin
      chk("in_ready", bus.in_ready, model_q.size() < DEPTH);
      chk("out_valid", bus.out_valid, model_q.size() != 0);
      if (model_q.size() != 0) begin
         chk("out_data", bus.out_data, model_q[0][31:0]);
         chk("out_check", bus.out_check, model_q[0][39:32]);
      end
      chk("word_cnt", word_cnt, m_cnt);
   end

   logic [31:0] enc_d [4] = '{32'h0000_0000, 32'h0000_0001, 32'h0001_0000, 32'hFFFF_FFFF};
   logic [7:0]  enc_c [4] = '{8'h00, 8'h51, 8'h15, 8'h00};
   logic [31:0] rd;

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.out_ready  = 1'b0;
      bus2.in_valid  = 1'b0;
      bus2.in_data   = '0;
      bus2.out_ready = 1'b0;
`ifdef ECC_ERR_INJECT_EN
      inj_en  = 1'b0;
      inj_bit = '0;
`endif
      repeat (2) @(posedge CK);
      #1;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_word_cnt", word_cnt, 16'd0);
      chk("rst_out_data", bus.out_data, 32'd0);
      chk("rst_out_check", bus.out_check, 8'd0);
      #2 RN = 1'b1;

      // Basic encodes, each into an empty buffer
      for (int k = 0; k < 4; k++) begin
         @(posedge CK);
         #1;
         bus.out_ready = 1'b1;
         bus.in_valid  = 1'b1;
         bus.in_data   = enc_d[k];
         @(posedge CK);
         #1 bus.in_valid = 1'b0;
         @(negedge CK);
         chk("enc_valid", bus.out_valid, 1'b1);
         chk("enc_data", bus.out_data, enc_d[k]);
         chk("enc_check", bus.out_check, enc_c[k]);
      end

      // Backpressure with a two-entry buffer
      @(posedge CK);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hA5A5_A5A5;
      @(posedge CK);
      #1 bus.in_data = 32'h1234_5678;
      @(posedge CK);
      #1 bus.in_data = 32'hDEAD_BEEF;
      @(negedge CK);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_hold", bus.out_data, 32'hA5A5_A5A5);
      @(posedge CK);
      #1;
      @(negedge CK);
      chk("bp_refused_cnt", word_cnt, 16'd6);
      chk("bp_hold2", bus.out_data, 32'hA5A5_A5A5);
      @(posedge CK);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge CK);
      chk("bp_first", bus.out_data, 32'hA5A5_A5A5);
      @(posedge CK);
      #1;
      @(negedge CK);
      chk("bp_second", bus.out_data, 32'h1234_5678);
      @(posedge CK);
      #1;

      // Occupancy 1 with push and pop together every cycle
      RN = 1'b0;
      #2 RN = 1'b1;
      @(posedge CK);
      #1;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_data   = $urandom;
      for (int i = 0; i < 9; i++) begin
         @(posedge CK);
         #1;
         bus.in_data = $urandom;
         if (i == 8) bus.in_valid = 1'b0;
         @(negedge CK);
         chk("occ1_valid", bus.out_valid, 1'b1);
      end
      chk("occ1_cnt", word_cnt, 16'd9);

      // Asynchronous reset with two words buffered
      @(posedge CK);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = $urandom;
      @(posedge CK);
      #1 bus.in_data = $urandom;
      @(posedge CK);
      #1 bus.in_valid = 1'b0;
      @(negedge CK);
      chk("pre_rst_full", bus.in_ready, 1'b0);
      #1 RN = 1'b0;
      #1;
      chk("arst_out_valid", bus.out_valid, 1'b0);
      chk("arst_word_cnt", word_cnt, 16'd0);
      chk("arst_in_ready", bus.in_ready, 1'b1);
      chk("arst_out_data", bus.out_data, 32'd0);
      chk("arst_out_check", bus.out_check, 8'd0);
      rd = 32'h0BAD_F00D;
      bus.in_valid = 1'b1;
      bus.in_data  = rd;
      #1 RN = 1'b1;
      @(posedge CK);
      #1 bus.in_valid = 1'b0;
      @(negedge CK);
      chk("post_rst_valid", bus.out_valid, 1'b1);
      chk("post_rst_cnt", word_cnt, 16'd1);
      chk("post_rst_data", bus.out_data, rd);
      @(posedge CK);
      #1 bus.out_ready = 1'b1;
      repeat (3) @(posedge CK);
      #1;

`ifdef ECC_ERR_INJECT_EN
      bus.in_valid = 1'b1;
      bus.in_data  = '0;
      inj_en       = 1'b1;
      inj_bit      = 6'd5;
      @(posedge CK);
      #1;
      bus.in_valid = 1'b0;
      inj_en       = 1'b0;
      @(negedge CK);
      chk("inj5_data", bus.out_data, 32'h0000_0020);
      chk("inj5_check", bus.out_check, 8'h00);
      @(posedge CK);
      #1;
      bus.in_valid = 1'b1;
      inj_en       = 1'b1;
      inj_bit      = 6'd45;
      @(posedge CK);
      #1;
      bus.in_valid = 1'b0;
      inj_en       = 1'b0;
      @(negedge CK);
      chk("inj45_data", bus.out_data, 32'h0000_0000);
      chk("inj45_check", bus.out_check, 8'h00);
      @(posedge CK);
      #1;
`endif

      // Random traffic checked by the compare process
      for (int i = 0; i < 400; i++) begin
         bus.in_valid  = ($urandom_range(0, 2) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 7))
            0:       bus.in_data = 32'h0000_0000;
            1:       bus.in_data = 32'hFFFF_FFFF;
            default: bus.in_data = $urandom;
         endcase
`ifdef ECC_ERR_INJECT_EN
         inj_en  = ($urandom_range(0, 3) == 0);
         inj_bit = 6'($urandom_range(0, 63));
`endif
         @(posedge CK);
         #1;
      end
      bus.in_valid = 1'b0;
`ifdef ECC_ERR_INJECT_EN
      inj_en = 1'b0;
`endif

      // Counter wrap on the 4-bit instance: 17 pushes
      bus2.out_ready = 1'b1;
      bus2.in_valid  = 1'b1;
      for (int i = 0; i < 17; i++) begin
         bus2.in_data = $urandom;
         @(posedge CK);
         #1;
      end
      bus2.in_valid = 1'b0;
      @(negedge CK);
      chk("wrap_cnt", word_cnt2, 4'd1);

      @(posedge CK);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ecc_enc_stage.md
ECC_ENC_STAGE -- requirements
Module: ecc_enc_stage

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, output buffer entries, legal values 2, 4 or 8.
REQ-002 SHALL have parameter CNT_W, default 16, width of the accepted-word counter.
REQ-003 SHALL have port CK, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port RN, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, upstream word present.
REQ-006 SHALL have port in_ready, output, 1, stage can accept a word this cycle.
REQ-007 SHALL have port in_data, input, 32, data bits d0..d31, with d0 as the LSB.
REQ-008 SHALL have port out_valid, output, 1, codeword at buffer head is valid.
REQ-009 SHALL have port out_ready, input, 1, downstream SEC decoder accepts the head word.
REQ-010 SHALL have port out_data, output, 32, data bits of the head codeword.
REQ-011 SHALL have port out_check, output, 8, check bits c0..c7 of the head codeword, with c0 as the LSB.
REQ-012 SHALL have port word_cnt, output, CNT_W, count of accepted input words.

Function
REQ-013 SHALL compute check bits as even parity over these 12-bit data sets:
- c0 = d16..d23, d0, d4, d8, d12
- c1 = d24..d31, d1, d5, d9, d13
- c2 = d16..d19, d24..d27, d2, d6, d10, d14
- c3 = d20..d23, d28..d31, d3, d7, d11, d15
- c4 = d0..d7, d16, d20, d24, d28
- c5 = d8..d15, d17, d21, d25, d29
- c6 = d0..d3, d8..d11, d18, d22, d26, d30
- c7 = d4..d7, d12..d15, d19, d23, d27, d31
REQ-014 SHALL encode so that a downstream decoder with its enable high sees an all-zero syndrome.
REQ-015 SHALL accept an input word on any cycle where in_valid and in_ready are both high (push).
REQ-016 SHALL transfer the head codeword on any cycle where out_valid and out_ready are both high (pop).
REQ-017 SHALL store each pushed word with its check bits in a circular FIFO of FIFO_DEPTH entries; read and write pointers wrap modulo FIFO_DEPTH.
REQ-018 SHALL present a pushed word on out_valid/out_data/out_check one cycle after the push when the buffer was empty; there is no combinational input-to-output path.
REQ-019 SHALL drive in_ready as not FULL, decoded from registered occupancy only; it is independent of out_ready in the same cycle.
REQ-020 SHALL track occupancy state EMPTY (0), PART (1..FIFO_DEPTH-1) or FULL (FIFO_DEPTH):
- push without pop increments occupancy;
- pop without push decrements it;
- simultaneous push and pop in PART holds occupancy and preserves order.
REQ-021 SHALL drive out_valid as not EMPTY.
REQ-022 SHALL hold out_data and out_check stable while out_valid is high and out_ready is low.
REQ-023 SHALL ignore in_valid when FULL and ignore out_ready when EMPTY, with no state change.
REQ-024 SHALL increment word_cnt on every push, wrapping from all-ones to zero.

Reset
REQ-025 SHALL, on RN low, immediately force:
- occupancy to EMPTY and pointers to 0;
- out_valid=0, in_ready=1, word_cnt=0;
- out_data=0, out_check=0.
REQ-026 SHALL discard buffered words when RN is asserted mid-operation, and SHALL accept a push on the first rising CK edge after RN deasserts.

Configuration
REQ-027 SHALL, when macro ECC_ERR_INJECT_EN is defined:
- add inputs inj_en (1 bit) and inj_bit (6 bits);
- on a push with inj_en=1, invert bit inj_bit of the stored 40-bit codeword, where 0..31 are data and 32..39 are c0..c7;
- make no change for inj_bit of 40 or more.
REQ-028 SHALL, without ECC_ERR_INJECT_EN, omit inj_en and inj_bit and store every codeword unmodified.

Verification
REQ-029 SHALL cover basic encodes, each pushed into an empty buffer with out_ready=1:
- in_data 0x00000000 -> out_check 0x00, one cycle later;
- in_data 0x00000001 -> out_check 0x51;
- in_data 0x00010000 -> out_check 0x15;
- in_data 0xFFFFFFFF -> out_check 0x00.
REQ-030 SHALL cover backpressure: out_ready=0 with FIFO_DEPTH=2, push 0xA5A5A5A5 then 0x12345678 -> in_ready=0 after the second push, third word refused, out_data holds 0xA5A5A5A5; raise out_ready -> outputs in push order.
REQ-031 SHALL cover occupancy 1 with push and pop in the same cycle every cycle for 8 cycles -> occupancy stays 1, out_valid stays 1, word_cnt=8 (plus the initial push).
REQ-032 SHALL cover RN pulsed low with 2 words buffered -> out_valid=0 and word_cnt=0 without waiting for CK, in_ready=1.
REQ-033 SHALL cover, with ECC_ERR_INJECT_EN, in_data 0x00000000, inj_en=1, inj_bit=5 -> out_data 0x00000020, out_check 0x00; with inj_bit=45 -> unmodified codeword.
REQ-034 SHALL cover word_cnt wrap: CNT_W=4, 17 pushes -> word_cnt=1.
